// File: rtl/rollback_ctrl_pkg.sv
// Shared definitions for the mispredict recovery sequencer.
package rollback_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } rb_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/rollback_ctrl_if.sv
// Bundles the ROB commit inputs, drain status and all recovery/predictor outputs.
interface rollback_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 IsBranch_in;
  logic                 MisPredict_in;
  logic                 BranchTaken_in;
  logic [31:0]          BranchInstPC_in;
  logic [31:0]          JumpAddr_in;
  logic                 fu_busy;
  logic                 lsq_store_pending;
  logic                 rollback;
  logic                 stall_fetch;
  logic                 redirect_en;
  logic [31:0]          redirect_pc;
  logic                 bp_update_en;
  logic [31:0]          bp_update_pc;
  logic                 bp_update_taken;
  logic [CNT_WIDTH-1:0] mispredict_cnt;
  logic                 drain_timeout_err;

  modport master (
    output IsBranch_in, MisPredict_in, BranchTaken_in, BranchInstPC_in, JumpAddr_in,
           fu_busy, lsq_store_pending,
    input  rollback, stall_fetch, redirect_en, redirect_pc, bp_update_en, bp_update_pc,
           bp_update_taken, mispredict_cnt, drain_timeout_err
  );

  modport slave (
    input  IsBranch_in, MisPredict_in, BranchTaken_in, BranchInstPC_in, JumpAddr_in,
           fu_busy, lsq_store_pending,
    output rollback, stall_fetch, redirect_en, redirect_pc, bp_update_en, bp_update_pc,
           bp_update_taken, mispredict_cnt, drain_timeout_err
  );
endinterface

// File: rtl/rollback_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rollback_ctrl.sv
// Mispredict recovery: flush, drain in-flight work, then a single PC redirect.
// Also forwards every committed branch to the predictor.
module rollback_ctrl
  import rollback_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned DRAIN_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic            clk,
  input  logic            rst,
  rollback_ctrl_if.slave  bus
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

  rb_state_t      state, state_nx;
  logic [3:0]     flush_cnt, flush_nx;
  logic [7:0]     drain_cnt, drain_nx;
  logic [31:0]    target, target_nx;
  logic           accept, timeout_hit;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    state_nx    = state;
    flush_nx    = flush_cnt;
    drain_nx    = drain_cnt;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    target_nx   = bus.BranchTaken_in ? bus.JumpAddr_in : (bus.BranchInstPC_in + INST_BYTES);
    case (state)
      IDLE: begin
        if (bus.IsBranch_in && bus.MisPredict_in) begin
          accept   = 1'b1;
          state_nx = FLUSH;
          flush_nx = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end else begin
          flush_nx = flush_cnt + 4'd1;
        end
      end
      DRAIN: begin
        // A clean drain on the last allowed cycle is not counted as a timeout.
        if (!bus.fu_busy && !bus.lsq_store_pending) begin
          state_nx = REDIRECT;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nx    = REDIRECT;
          timeout_hit = 1'b1;
        end else begin
          drain_nx = drain_cnt + 8'd1;
        end
      end
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      flush_cnt             <= '0;
      drain_cnt             <= '0;
      target                <= '0;
      bus.rollback          <= 1'b0;
      bus.stall_fetch       <= 1'b0;
      bus.redirect_en       <= 1'b0;
      bus.redirect_pc       <= '0;
      bus.bp_update_en      <= 1'b0;
      bus.bp_update_pc      <= '0;
      bus.bp_update_taken   <= 1'b0;
      bus.drain_timeout_err <= 1'b0;
    end else begin
      state               <= state_nx;
      flush_cnt           <= flush_nx;
      drain_cnt           <= drain_nx;
      if (accept) target  <= target_nx;
      bus.rollback        <= (state_nx == FLUSH);
      bus.stall_fetch     <= (state_nx != IDLE);
      bus.redirect_en     <= (state_nx == REDIRECT);
      bus.redirect_pc     <= (state_nx == REDIRECT) ? target : '0;
      bus.bp_update_en    <= bus.IsBranch_in;
      bus.bp_update_pc    <= bus.IsBranch_in ? bus.BranchInstPC_in : '0;
      bus.bp_update_taken <= bus.IsBranch_in & bus.BranchTaken_in;
      if (timeout_hit) bus.drain_timeout_err <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (cnt_q)
  );

  assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_rollback_ctrl.sv
// Scoreboard bench for rollback_ctrl: directed scenarios followed by random commits.
module tb_rollback_ctrl;

  localparam int F    = 2;
  localparam int DT   = 15;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rb;
    logic          st;
    logic          re;
    logic          bpe;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  logic [32:0] bp_q[$];

  bit          m_seq, m_redir, m_bpe, m_err;
  int          m_pos, m_cnt;
  logic [31:0] m_target;

  rollback_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  rollback_ctrl #(.FLUSH_CYCLES(F), .DRAIN_TIMEOUT(DT), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a sequence is a numbered run of cycles; 1..F flush, later ones drain.
  task automatic model_edge();
    m_bpe = bus.IsBranch_in;
    if (bus.IsBranch_in) bp_q.push_back({bus.BranchTaken_in, bus.BranchInstPC_in});
    if (!m_seq) begin
      if (bus.IsBranch_in && bus.MisPredict_in) begin
        m_seq    = 1;
        m_pos    = 1;
        m_redir  = 0;
        m_target = bus.BranchTaken_in ? bus.JumpAddr_in : bus.BranchInstPC_in + 32'd4;
        redir_q.push_back(m_target);
        if (m_cnt < CMAX) m_cnt++;
      end
    end else if (m_redir) begin
      m_seq   = 0;
      m_redir = 0;
    end else if (m_pos <= F) begin
      m_pos++;
    end else if (!bus.fu_busy && !bus.lsq_store_pending) begin
      m_redir = 1;
    end else if (m_pos - F == DT) begin
      m_redir = 1;
      m_err   = 1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic model_clear();
    m_seq = 0; m_redir = 0; m_bpe = 0; m_err = 0; m_pos = 0; m_cnt = 0; m_target = '0;
    redir_q.delete();
    bp_q.delete();
  endtask

  task automatic applyStimulus(input bit r, ib, mp, tk, input logic [31:0] pc, ja,
                               input bit fb, lsq);
    exp_t e;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    rst                   = r;
    bus.IsBranch_in       = ib;
    bus.MisPredict_in     = mp;
    bus.BranchTaken_in    = tk;
    bus.BranchInstPC_in   = pc;
    bus.JumpAddr_in       = ja;
    bus.fu_busy           = fb;
    bus.lsq_store_pending = lsq;
    if (!r) model_clear();
    e.rb  = m_seq && !m_redir && (m_pos <= F);
    e.st  = m_seq;
    e.re  = m_redir;
    e.bpe = m_bpe;
    e.cnt = m_cnt[CW-1:0];
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit fb, lsq);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, fb, lsq);
  endtask

  // Monitor: per-cycle control snapshot, plus payload checks whenever a strobe is presented.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] t;
    logic [32:0] b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rollback", bus.rollback, e.rb);
      checkOutput("stall_fetch", bus.stall_fetch, e.st);
      checkOutput("redirect_en", bus.redirect_en, e.re);
      checkOutput("bp_update_en", bus.bp_update_en, e.bpe);
      checkOutput("mispredict_cnt", bus.mispredict_cnt, e.cnt);
      checkOutput("drain_timeout_err", bus.drain_timeout_err, e.err);
      if (bus.redirect_en) begin
        if (redir_q.size() == 0) checkOutput("redirect_unexpected", bus.redirect_en, 0);
        else begin
          t = redir_q.pop_front();
          checkOutput("redirect_pc", bus.redirect_pc, t);
        end
      end else checkOutput("redirect_pc_idle", bus.redirect_pc, 0);
      if (bus.bp_update_en) begin
        if (bp_q.size() == 0) checkOutput("bp_unexpected", bus.bp_update_en, 0);
        else begin
          b = bp_q.pop_front();
          checkOutput("bp_update_pc", bus.bp_update_pc, b[31:0]);
          checkOutput("bp_update_taken", bus.bp_update_taken, b[32]);
        end
      end else checkOutput("bp_payload_idle", {bus.bp_update_taken, bus.bp_update_pc}, 0);
    end
  end

  initial begin
    int burst;
    bit fb, lsq;
    model_clear();
    bus.IsBranch_in = 0; bus.MisPredict_in = 0; bus.BranchTaken_in = 0;
    bus.BranchInstPC_in = '0; bus.JumpAddr_in = '0; bus.fu_busy = 0; bus.lsq_store_pending = 0;

    // Reset held with random commit traffic
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                    1'($urandom), 1'($urandom));
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    idle(10, 0, 0);

    // Taken mispredict, no drain wait
    applyStimulus(1, 1, 1, 1, 32'h0000_0100, 32'h0000_0400, 0, 0);
    idle(8, 0, 0);

    // Not-taken mispredict, fu_busy held for five cycles
    applyStimulus(1, 1, 1, 0, 32'h0000_0120, 32'h0000_0999, 1, 0);
    idle(4, 1, 0);
    idle(6, 0, 0);

    // Drain timeout, then a clean sequence with the error still sticky
    applyStimulus(1, 1, 1, 1, 32'h0000_0200, 32'h0000_0800, 0, 1);
    idle(22, 0, 1);
    idle(3, 0, 0);
    applyStimulus(1, 1, 1, 1, 32'h0000_0300, 32'h0000_0C00, 0, 0);
    idle(6, 0, 0);

    // Second mispredict while draining must not retarget; MisPredict without IsBranch ignored
    applyStimulus(1, 1, 1, 1, 32'h0000_0400, 32'h0000_1000, 1, 0);
    idle(3, 1, 0);
    applyStimulus(1, 1, 1, 1, 32'h0000_0500, 32'hDEAD_0000, 1, 0);
    idle(2, 1, 0);
    idle(5, 0, 0);
    applyStimulus(1, 0, 1, 1, 32'h0000_0600, 32'h0000_2000, 0, 0);
    idle(3, 0, 0);

    // PC wrap on not-taken
    applyStimulus(1, 1, 1, 0, 32'hFFFF_FFFC, 32'h1234_5678, 0, 0);
    idle(6, 0, 0);

    // Reset during FLUSH aborts the redirect
    applyStimulus(1, 1, 1, 1, 32'h0000_0700, 32'h0000_3000, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    idle(8, 0, 0);

    // Random commits; enough mispredicts to saturate the counter
    burst = 0;
    for (int n = 0; n < 900; n++) begin
      if (burst == 0 && ($urandom % 40) == 0) burst = $urandom_range(3, 24);
      fb  = (burst > 0) ? 1'b1 : (($urandom % 5) == 0);
      lsq = (burst > 0) ? 1'($urandom) : (($urandom % 7) == 0);
      if (burst > 0) burst--;
      applyStimulus((($urandom % 250) == 0) ? 1'b0 : 1'b1,
                    (($urandom % 3) == 0), 1'($urandom), 1'($urandom),
                    (($urandom % 6) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom, fb, lsq);
    end
    idle(30, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("redirect_outstanding", redir_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
